// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   INST_BYTES    : byte stride between sequential fetch addresses.
//   NOP_INST      : canonical "addi x0, x0, 0", used by decode to fill bubbles.
//   fetch_entry_t : RV32 view of one instruction-queue entry {pc, inst}.
package riscv_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer used as the fetch instruction queue.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   flush            : empties the buffer (pointers and count to zero)
//   push, push_data  : write push_data at the tail
//   pop              : retire the head entry
//   head_data        : combinational read of the head entry
//   count            : number of valid entries
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_BITS-1:0]         push_data,
    input  logic                         pop,
    output logic [DATA_BITS-1:0]         head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop)  head <= wrap_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, fixed-latency
// instruction memory requests, and a queue toward decode.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   inst_addr_o, inst_ce_o     : memory request (address always = fetch PC)
//   inst_i                     : memory data, MEM_LATENCY cycles after request
//   redirect_i, redirect_pc_i  : branch flush and new PC (word aligned here)
//   id_ready_i                 : decode accepts the head entry
//   if_valid_o, if_pc_o, if_inst_o : head entry toward decode
module riscv_fetch_queue
    import riscv_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = 32,
    parameter int                       QUEUE_DEPTH   = 4,
    parameter int                       MEM_LATENCY   = 1,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [WORD_BITWIDTH-1:0] inst_addr_o,
    output logic                     inst_ce_o,
    input  logic [WORD_BITWIDTH-1:0] inst_i,
    input  logic                     redirect_i,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc_i,
    input  logic                     id_ready_i,
    output logic                     if_valid_o,
    output logic [WORD_BITWIDTH-1:0] if_pc_o,
    output logic [WORD_BITWIDTH-1:0] if_inst_o
);

    localparam int W  = WORD_BITWIDTH;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = $clog2(QUEUE_DEPTH + MEM_LATENCY + 1);

    logic [W-1:0]           fetch_pc;
    logic [MEM_LATENCY-1:0] trk_valid;
    logic [W-1:0]           trk_pc [MEM_LATENCY];
    logic [CW-1:0]          count;
    logic [SW-1:0]          inflight;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [2*W-1:0]         head_data;
    logic                   unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + SW'(trk_valid[i]);
        end
    end

    // Credit check: every outstanding request already owns a queue slot,
    // so a response can always be pushed without a full check.
    assign issue      = !rst && !redirect_i
                        && ((SW'(count) + inflight) < SW'(QUEUE_DEPTH));
    assign push       = trk_valid[MEM_LATENCY-1] && !redirect_i;
    assign if_valid_o = !rst && !redirect_i && (count != '0);
    assign pop        = if_valid_o && id_ready_i;

    assign inst_ce_o   = issue;
    assign inst_addr_o = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[W-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + W'(INST_BYTES);
        end
    end

    // In-flight tracker: slot 0 is the request just issued, the last slot
    // lines up with inst_i for that request.
    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            trk_valid <= '0;
        end else begin
            trk_valid[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        trk_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            trk_pc[i] <= trk_pc[i-1];
        end
    end

    fetch_fifo #(
        .DATA_BITS (2 * W),
        .DEPTH     (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({trk_pc[MEM_LATENCY-1], inst_i}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign if_pc_o   = head_data[2*W-1:W];
    assign if_inst_o = head_data[W-1:0];

endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    function automatic int dep_of(input int g);
        case (g)
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a   [4];
    logic        redir_a [4];
    logic [31:0] rpc_a   [4];
    logic        rdy_a   [4];
    logic [31:0] addr_a  [4];
    logic        ce_a    [4];
    logic        vld_a   [4];
    logic [31:0] pc_a    [4];
    logic [31:0] inst_a  [4];

    int n_checks = 0;
    int n_fail   = 0;

    // DUT 0: depth 4 / latency 1, DUT 1: 4 / 2, DUT 2: 5 / 3, DUT 3: 4 / 3.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = lat_of(g);
        logic [31:0] addr_pipe [3];
        logic [31:0] addr, pc, inst, mem_data;
        logic        ce, vld;

        always @(posedge clk) begin
            addr_pipe[0] <= addr;
            addr_pipe[1] <= addr_pipe[0];
            addr_pipe[2] <= addr_pipe[1];
        end
        assign mem_data = addr_pipe[LAT-1] ^ KEY;

        riscv_fetch_queue #(
            .WORD_BITWIDTH (32),
            .QUEUE_DEPTH   (dep_of(g)),
            .MEM_LATENCY   (LAT),
            .RESET_PC      (32'h0)
        ) u_dut (
            .clk           (clk),
            .rst           (rst_a[g]),
            .inst_addr_o   (addr),
            .inst_ce_o     (ce),
            .inst_i        (mem_data),
            .redirect_i    (redir_a[g]),
            .redirect_pc_i (rpc_a[g]),
            .id_ready_i    (rdy_a[g]),
            .if_valid_o    (vld),
            .if_pc_o       (pc),
            .if_inst_o     (inst)
        );

        assign addr_a[g] = addr;
        assign ce_a[g]   = ce;
        assign vld_a[g]  = vld;
        assign pc_a[g]   = pc;
        assign inst_a[g] = inst;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ce_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ce dut%0d: got %b expected 0", k, ce_a[k]);
            end
            n_checks++;
            if (vld_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid dut%0d: got %b expected 0", k, vld_a[k]);
            end
            n_checks++;
            if (addr_a[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_addr dut%0d: got %h expected 00000000", k, addr_a[k]);
            end
        end
    endtask

    task automatic test_stream();
        rdy_a[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            rst_a[0] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (ce_a[0] !== 1'b1 || addr_a[0] !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_issue c%0d: got ce=%b addr=%h expected ce=1 addr=%h",
                         k, ce_a[0], addr_a[0], 32'(4 * k));
            end
            n_checks++;
            if (vld_a[0] !== (k >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: got %b expected %b", k, vld_a[0], k >= 2);
            end
            if (k >= 2) begin
                n_checks++;
                if (pc_a[0] !== 32'(4 * (k - 2)) || inst_a[0] !== (32'(4 * (k - 2)) ^ KEY)) begin
                    n_fail++;
                    $display("FAIL stream_data c%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                             k, pc_a[0], inst_a[0], 32'(4 * (k - 2)), 32'(4 * (k - 2)) ^ KEY);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int ce_cnt = 0;
        cyc();
        rst_a[0] = 1'b1;
        rdy_a[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            rst_a[0] = 1'b0;
            @(negedge clk);
            if (ce_a[0] === 1'b1) ce_cnt++;
            if (k >= 2) begin
                n_checks++;
                if (vld_a[0] !== 1'b1 || pc_a[0] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: got valid=%b pc=%h expected valid=1 pc=00000000",
                             k, vld_a[0], pc_a[0]);
                end
            end
        end
        n_checks++;
        if (ce_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got ce=%b expected 0", ce_a[0]);
        end
        n_checks++;
        if (ce_cnt != 4) begin
            n_fail++;
            $display("FAIL bp_req_count: got %0d expected 4", ce_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            rdy_a[0] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (vld_a[0] !== 1'b1 || pc_a[0] !== 32'(4 * k) || inst_a[0] !== (32'(4 * k) ^ KEY)) begin
                n_fail++;
                $display("FAIL bp_drain %0d: got valid=%b pc=%h inst=%h expected valid=1 pc=%h",
                         k, vld_a[0], pc_a[0], inst_a[0], 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        cyc();
        rst_a[1]   = 1'b1;
        rdy_a[1]   = 1'b1;
        redir_a[1] = 1'b0;
        cyc();
        rst_a[1] = 1'b0;
        cyc();
        cyc();
        cyc();
        redir_a[1] = 1'b1;
        rpc_a[1]   = 32'h100;
        @(negedge clk);
        n_checks++;
        if (ce_a[1] !== 1'b0 || vld_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle: got ce=%b valid=%b expected 0 0", ce_a[1], vld_a[1]);
        end
        for (int k = 1; k <= 5; k++) begin
            cyc();
            redir_a[1] = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (ce_a[1] !== 1'b1 || addr_a[1] !== 32'h100) begin
                    n_fail++;
                    $display("FAIL redir_issue: got ce=%b addr=%h expected ce=1 addr=00000100",
                             ce_a[1], addr_a[1]);
                end
            end
            n_checks++;
            if (vld_a[1] !== (k >= 4)) begin
                n_fail++;
                $display("FAIL redir_valid r+%0d: got %b expected %b", k, vld_a[1], k >= 4);
            end
            if (k >= 4) begin
                n_checks++;
                if (pc_a[1] !== 32'(32'h100 + 4 * (k - 4))
                    || inst_a[1] !== (32'(32'h100 + 4 * (k - 4)) ^ KEY)) begin
                    n_fail++;
                    $display("FAIL redir_data r+%0d: got pc=%h inst=%h expected pc=%h",
                             k, pc_a[1], inst_a[1], 32'(32'h100 + 4 * (k - 4)));
                end
            end
        end
    endtask

    task automatic test_redirect_align();
        cyc();
        redir_a[1] = 1'b1;
        rpc_a[1]   = 32'h300;
        @(negedge clk);
        n_checks++;
        if (ce_a[1] !== 1'b0 || vld_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL align_cycle: got ce=%b valid=%b expected 0 0", ce_a[1], vld_a[1]);
        end
        cyc();
        rpc_a[1] = 32'h203;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            redir_a[1] = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (ce_a[1] !== 1'b1 || addr_a[1] !== 32'h200) begin
                    n_fail++;
                    $display("FAIL align_issue: got ce=%b addr=%h expected ce=1 addr=00000200",
                             ce_a[1], addr_a[1]);
                end
            end
            if (k >= 4) begin
                n_checks++;
                if (vld_a[1] !== 1'b1 || pc_a[1] !== 32'(32'h200 + 4 * (k - 4))) begin
                    n_fail++;
                    $display("FAIL align_data r+%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                             k, vld_a[1], pc_a[1], 32'(32'h200 + 4 * (k - 4)));
                end
            end
        end
    endtask

    // Ordering under a ready pattern; returns pops and empty cycles seen
    // after a short warm-up.
    task automatic test_order(input int k, input int ncyc, input bit rand_rdy,
                              output int pops, output int bubbles);
        logic [31:0] exp_pc = 32'h0;
        pops    = 0;
        bubbles = 0;
        cyc();
        rst_a[k]   = 1'b1;
        redir_a[k] = 1'b0;
        cyc();
        rst_a[k] = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            rdy_a[k] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (i >= 8 && vld_a[k] !== 1'b1) bubbles++;
            if (vld_a[k] === 1'b1 && rdy_a[k] === 1'b1) begin
                n_checks++;
                if (pc_a[k] !== exp_pc || inst_a[k] !== (exp_pc ^ KEY)) begin
                    n_fail++;
                    $display("FAIL order dut%0d pop%0d: got pc=%h inst=%h expected pc=%h",
                             k, pops, pc_a[k], inst_a[k], exp_pc);
                end
                exp_pc += 32'd4;
                pops++;
            end
        end
    endtask

    task automatic test_random_ready();
        int pops, bubbles;
        test_order(2, 200, 1'b1, pops, bubbles);
        n_checks++;
        if (pops < 60) begin
            n_fail++;
            $display("FAIL rand_progress dut2: got %0d pops expected >= 60", pops);
        end
        test_order(3, 60, 1'b0, pops, bubbles);
        n_checks++;
        if (bubbles == 0 || pops < 30) begin
            n_fail++;
            $display("FAIL shallow_bubbles dut3: got bubbles=%0d pops=%0d expected bubbles>0 pops>=30",
                     bubbles, pops);
        end
        n_checks++;
        if (pops > 52) begin
            n_fail++;
            $display("FAIL shallow_rate dut3: got %0d pops expected <= 52", pops);
        end
        test_order(3, 150, 1'b1, pops, bubbles);
    endtask

    task automatic test_reset_midstream();
        cyc();
        rst_a[0]   = 1'b1;
        rdy_a[0]   = 1'b0;
        redir_a[0] = 1'b0;
        cyc();
        rst_a[0]   = 1'b0;
        redir_a[0] = 1'b1;
        rpc_a[0]   = 32'h500;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            redir_a[0] = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (vld_a[0] !== 1'b1 || pc_a[0] !== 32'h500) begin
            n_fail++;
            $display("FAIL mid_prefill: got valid=%b pc=%h expected valid=1 pc=00000500",
                     vld_a[0], pc_a[0]);
        end
        cyc();
        rst_a[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (vld_a[0] !== 1'b0 || ce_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_cycle: got valid=%b ce=%b expected 0 0", vld_a[0], ce_a[0]);
        end
        cyc();
        rst_a[0] = 1'b0;
        rdy_a[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (vld_a[0] !== 1'b0 || addr_a[0] !== 32'h0 || ce_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart: got valid=%b addr=%h ce=%b expected 0 00000000 1",
                     vld_a[0], addr_a[0], ce_a[0]);
        end
        for (int j = 1; j < 9; j++) begin
            cyc();
            @(negedge clk);
            n_checks++;
            if (vld_a[0] !== (j >= 2) || (j >= 2 && pc_a[0] !== 32'(4 * (j - 2)))) begin
                n_fail++;
                $display("FAIL mid_after j%0d: got valid=%b pc=%h expected valid=%b pc=%h",
                         j, vld_a[0], pc_a[0], j >= 2, 32'(4 * (j - 2)));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_a[k]   = 1'b1;
            redir_a[k] = 1'b0;
            rpc_a[k]   = 32'h0;
            rdy_a[k]   = 1'b0;
        end
        cyc();
        cyc();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_align();
        test_random_ready();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
